wilson_scheduler: RTL and testbench

- Time-multiplexes one shared `wilson` neuron datapath across N_NEURONS neurons.
- Holds per-neuron stimulus current and v/r state in a local register file.
- Sequences N_NEURONS × num_steps updates after a start handshake and exposes a read port for results.
- Sits between the SNN top level and the `wilson` instance; replaces the free-running v_prev/r_prev feedback registers.

---
 rtl/snn_pkg.sv | 39 +++
 rtl/neuron_state_ram.sv | 119 +++++++++++
 rtl/wilson_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_wilson_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared constants, types and helpers for the SNN neuron scheduler.
// Data words are sign-magnitude Q15.16 (bit 31 is the sign).
// The scheduler's optional spike counters are enabled by the SPIKE_COUNT_EN macro.
package snn_pkg;

  localparam int SNN_WIDTH = 32;
  localparam int FRAC_BITS = 16;
  localparam int SIGN_BIT  = 31;

  // Default neuron state: v = -0.8, r = 0.
  localparam logic [31:0] SNN_INIT_V   = 32'h8000CCCD;
  localparam logic [31:0] SNN_INIT_R   = 32'h00000000;
  localparam logic [31:0] SNN_SPIKE_TH = 32'h00004000;

  // Step counter and datapath-latency counter widths.
  localparam int STEP_W = 16;
  localparam int LAT_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // Sign-magnitude "a > b". Negative zero is treated as zero.
  function automatic logic sm_gt(input logic [31:0] a, input logic [31:0] b);
    logic a_neg;
    logic b_neg;
    a_neg = a[SIGN_BIT] && (a[SIGN_BIT-1:0] != '0);
    b_neg = b[SIGN_BIT] && (b[SIGN_BIT-1:0] != '0);
    if (!a_neg && b_neg) return 1'b1;
    if (a_neg && !b_neg) return 1'b0;
    if (!a_neg) return a[SIGN_BIT-1:0] > b[SIGN_BIT-1:0];
    return a[SIGN_BIT-1:0] < b[SIGN_BIT-1:0];
  endfunction

endpackage

// File: rtl/neuron_state_ram.sv
// neuron_state_ram: per-neuron register file holding stimulus current and v/r state.
// Configuration write port, datapath write-back port, bulk init, an asynchronous
// issue read port and a registered readout port.
// With SPIKE_COUNT_EN defined it also keeps a 16-bit saturating spike counter per neuron.
module neuron_state_ram
  import snn_pkg::*;
#(
  parameter int N = 8,
  parameter int WIDTH = SNN_WIDTH,
  parameter logic [WIDTH-1:0] INIT_V = WIDTH'(SNN_INIT_V),
  parameter logic [WIDTH-1:0] INIT_R = WIDTH'(SNN_INIT_R),
`ifdef SPIKE_COUNT_EN
  parameter logic [WIDTH-1:0] SPIKE_TH = WIDTH'(SNN_SPIKE_TH),
`endif
  localparam int AW = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [AW-1:0]    cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  input  logic             init_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_v_i,
  input  logic [WIDTH-1:0] wr_r_i,
  input  logic [AW-1:0]    iss_addr_i,
  output logic [WIDTH-1:0] iss_current_o,
  output logic [WIDTH-1:0] iss_v_o,
  output logic [WIDTH-1:0] iss_r_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_v_o,
  output logic [WIDTH-1:0] rd_r_o
`ifdef SPIKE_COUNT_EN
  ,
  output logic [15:0]      rd_spikes_o
`endif
);

  logic [WIDTH-1:0] cur_q [N];
  logic [WIDTH-1:0] v_q   [N];
  logic [WIDTH-1:0] r_q   [N];
  logic [WIDTH-1:0] rd_v_q;
  logic [WIDTH-1:0] rd_r_q;

  // Stimulus currents: only the configuration port writes them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) cur_q[i] <= '0;
    end else if (cfg_we_i) begin
      cur_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Neuron v/r state: bulk init or datapath write-back (never both in one cycle).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        v_q[i] <= INIT_V;
        r_q[i] <= INIT_R;
      end
    end else if (init_i) begin
      for (int i = 0; i < N; i++) begin
        v_q[i] <= INIT_V;
        r_q[i] <= INIT_R;
      end
    end else if (wr_en_i) begin
      v_q[wr_addr_i] <= wr_v_i;
      r_q[wr_addr_i] <= wr_r_i;
    end
  end

  // Registered readout, refreshed every cycle so mid-run values are visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_v_q <= '0;
      rd_r_q <= '0;
    end else begin
      rd_v_q <= v_q[rd_addr_i];
      rd_r_q <= r_q[rd_addr_i];
    end
  end

  assign iss_current_o = cur_q[iss_addr_i];
  assign iss_v_o       = v_q[iss_addr_i];
  assign iss_r_o       = r_q[iss_addr_i];
  assign rd_v_o        = rd_v_q;
  assign rd_r_o        = rd_r_q;

`ifdef SPIKE_COUNT_EN
  logic [15:0] spk_q [N];
  logic [15:0] rd_spk_q;
  logic        spike_hit;

  // A spike is an upward threshold crossing: old v at or below SPIKE_TH, new v above it.
  assign spike_hit = sm_gt(32'(wr_v_i), 32'(SPIKE_TH)) &&
                     !sm_gt(32'(v_q[wr_addr_i]), 32'(SPIKE_TH));

  // Saturating spike counters, cleared by reset and by init.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) spk_q[i] <= '0;
    end else if (init_i) begin
      for (int i = 0; i < N; i++) spk_q[i] <= '0;
    end else if (wr_en_i && spike_hit && (spk_q[wr_addr_i] != 16'hFFFF)) begin
      spk_q[wr_addr_i] <= spk_q[wr_addr_i] + 16'd1;
    end
  end

  // Spike count readout with the same latency as rd_v.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_spk_q <= '0;
    else       rd_spk_q <= spk_q[rd_addr_i];
  end

  assign rd_spikes_o = rd_spk_q;
`endif

endmodule

// File: rtl/wilson_scheduler.sv
// wilson_scheduler: time-multiplexes one shared wilson neuron datapath across
// N_NEURONS neurons for num_steps timesteps per run.
// Optional per-neuron spike counters are built when SPIKE_COUNT_EN is defined.
//
// Handshake: start is sampled only in IDLE. An accepted start with num_steps != 0
// raises busy from the next cycle until the run ends; every run, including a
// zero-step one, ends with exactly one done cycle, during which busy is low.
// cfg_we and init are honoured only while busy is low; start while busy is dropped.
module wilson_scheduler
  import snn_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int WIDTH = SNN_WIDTH,
  parameter int DP_LATENCY = 1,
  parameter logic [WIDTH-1:0] INIT_V = WIDTH'(SNN_INIT_V),
  parameter logic [WIDTH-1:0] INIT_R = WIDTH'(SNN_INIT_R),
`ifdef SPIKE_COUNT_EN
  parameter logic [WIDTH-1:0] SPIKE_TH = WIDTH'(SNN_SPIKE_TH),
`endif
  localparam int AW = $clog2(N_NEURONS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      num_steps,
  output logic             busy,
  output logic             done,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             init,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_v,
  output logic [WIDTH-1:0] rd_r,
  output logic [WIDTH-1:0] dp_current,
  output logic [WIDTH-1:0] dp_v_prev,
  output logic [WIDTH-1:0] dp_r_prev,
  input  logic [WIDTH-1:0] dp_v,
  input  logic [WIDTH-1:0] dp_r,
`ifdef SPIKE_COUNT_EN
  output logic [15:0]      rd_spikes,
`endif
  output logic [2:0]       dbg_state
);

  localparam logic [AW-1:0]    LAST_IDX  = AW'(N_NEURONS - 1);
  localparam logic [LAT_W-1:0] WAIT_INIT = LAT_W'(DP_LATENCY - 1);

  sched_state_t      state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] nsteps_q, nsteps_d;
  logic [LAT_W-1:0]  wait_q, wait_d;
  logic [WIDTH-1:0]  dp_cur_q, dp_cur_d;
  logic [WIDTH-1:0]  dp_vp_q, dp_vp_d;
  logic [WIDTH-1:0]  dp_rp_q, dp_rp_d;

  logic              wr_en;
  logic              idle_cfg;
  logic [WIDTH-1:0]  iss_current;
  logic [WIDTH-1:0]  iss_v;
  logic [WIDTH-1:0]  iss_r;

  assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign idle_cfg  = !busy;
  assign dbg_state = state_q;

  assign dp_current = dp_cur_q;
  assign dp_v_prev  = dp_vp_q;
  assign dp_r_prev  = dp_rp_q;

  neuron_state_ram #(
    .N      (N_NEURONS),
    .WIDTH  (WIDTH),
    .INIT_V (INIT_V),
    .INIT_R (INIT_R)
`ifdef SPIKE_COUNT_EN
    ,
    .SPIKE_TH (SPIKE_TH)
`endif
  ) u_ram (
    .clk_i         (clock),
    .rst_i         (reset),
    .cfg_we_i      (cfg_we && idle_cfg),
    .cfg_addr_i    (cfg_addr),
    .cfg_data_i    (cfg_data),
    .init_i        (init && idle_cfg),
    .wr_en_i       (wr_en),
    .wr_addr_i     (idx_q),
    .wr_v_i        (dp_v),
    .wr_r_i        (dp_r),
    .iss_addr_i    (idx_q),
    .iss_current_o (iss_current),
    .iss_v_o       (iss_v),
    .iss_r_o       (iss_r),
    .rd_addr_i     (rd_addr),
    .rd_v_o        (rd_v),
    .rd_r_o        (rd_r)
`ifdef SPIKE_COUNT_EN
    ,
    .rd_spikes_o   (rd_spikes)
`endif
  );

  // Sequencer state, counters and datapath operand registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      step_q   <= '0;
      nsteps_q <= '0;
      wait_q   <= '0;
      dp_cur_q <= '0;
      dp_vp_q  <= '0;
      dp_rp_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
      wait_q   <= wait_d;
      dp_cur_q <= dp_cur_d;
      dp_vp_q  <= dp_vp_d;
      dp_rp_q  <= dp_rp_d;
    end
  end

  // Next-state logic: ISSUE latches operands, WAIT covers datapath latency,
  // WRITE stores the result and advances neuron/step counters.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    wait_d   = wait_q;
    dp_cur_d = dp_cur_q;
    dp_vp_d  = dp_vp_q;
    dp_rp_d  = dp_rp_q;
    wr_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_steps != '0) begin
            nsteps_d = num_steps;
            step_d   = '0;
            idx_d    = '0;
            state_d  = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        // Operands become valid on the next edge and stay put through WAIT/WRITE.
        dp_cur_d = iss_current;
        dp_vp_d  = iss_v;
        dp_rp_d  = iss_r;
        wait_d   = WAIT_INIT;
        state_d  = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) state_d = WRITE;
        else              wait_d  = wait_q - 1'b1;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = ISSUE;
        end else begin
          idx_d  = '0;
          step_d = step_q + 1'b1;
          if (step_d == nsteps_q) state_d = DONE;
          else                    state_d = ISSUE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wilson_scheduler.sv
// tb_wilson_scheduler: randomized self-checking bench for wilson_scheduler.
// A behavioural wilson stand-in returns dp_v = dp_v_prev + 1 and
// dp_r = dp_r_prev + dp_current one cycle after the operands (or, in spike
// mode, toggles v between 0 and 0x8000). The reference model keeps per-neuron
// arrays and applies whole timesteps with plain arithmetic.
module tb_wilson_scheduler;

  localparam int N        = 8;
  localparam int W        = 32;
  localparam int LAT      = 1;
  localparam int PER_STEP = N * (LAT + 2);
  localparam logic [W-1:0] INIT_V = 32'h8000CCCD;
  localparam logic [W-1:0] INIT_R = 32'h00000000;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  num_steps = '0;
  logic         busy;
  logic         done;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic         init = 1'b0;
  logic [2:0]   rd_addr = '0;
  logic [W-1:0] rd_v, rd_r;
  logic [W-1:0] dp_current, dp_v_prev, dp_r_prev;
  logic [W-1:0] dp_v, dp_r;
  logic [2:0]   dbg_state;
`ifdef SPIKE_COUNT_EN
  logic [15:0]  rd_spikes;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int busy_drop;
  bit spike_mode = 1'b0;

  // Reference model and scoreboard.
  logic [W-1:0] m_cur [N];
  logic [W-1:0] m_v   [N];
  logic [W-1:0] m_r   [N];
  int           m_spk [N];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] obs_q [$];

  wilson_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_steps  (num_steps),
    .busy       (busy),
    .done       (done),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .init       (init),
    .rd_addr    (rd_addr),
    .rd_v       (rd_v),
    .rd_r       (rd_r),
    .dp_current (dp_current),
    .dp_v_prev  (dp_v_prev),
    .dp_r_prev  (dp_r_prev),
    .dp_v       (dp_v),
    .dp_r       (dp_r),
`ifdef SPIKE_COUNT_EN
    .rd_spikes  (rd_spikes),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock and reset block.
  always #5 clock = ~clock;

  // Behavioural datapath with one cycle of latency.
  always @(posedge clock) begin
    if (spike_mode) dp_v <= (dp_v_prev == 32'h00008000) ? 32'h0 : 32'h00008000;
    else            dp_v <= dp_v_prev + 32'd1;
    dp_r <= dp_r_prev + dp_current;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic bit above_th(input logic [W-1:0] x);
    return (x[31] == 1'b0) && (x[30:0] > 31'h4000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cur[i] = '0; m_v[i] = INIT_V; m_r[i] = INIT_R; m_spk[i] = 0;
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      m_v[i] = INIT_V; m_r[i] = INIT_R; m_spk[i] = 0;
    end
  endtask

  task automatic model_run(input int steps);
    logic [W-1:0] nv;
    for (int s = 0; s < steps; s++) begin
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(m_cur[i]);
        if (spike_mode) nv = (m_v[i] == 32'h00008000) ? 32'h0 : 32'h00008000;
        else            nv = m_v[i] + 32'd1;
        if (above_th(nv) && !above_th(m_v[i]) && m_spk[i] < 65535) m_spk[i]++;
        m_v[i] = nv;
        m_r[i] = m_r[i] + m_cur[i];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [W-1:0] data);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_data = data;
    tick();
    cfg_we = 1'b0;
    m_cur[addr] = data;
  endtask

  task automatic load_random_currents();
    for (int i = 0; i < N; i++) cfg_write(i, $urandom);
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    model_init();
  endtask

  task automatic read_neuron(input int i, output logic [W-1:0] v, output logic [W-1:0] r,
                             output logic [15:0] s);
    rd_addr = 3'(i);
    tick();
    v = rd_v;
    r = rd_r;
`ifdef SPIKE_COUNT_EN
    s = rd_spikes;
`else
    s = '0;
`endif
  endtask

  // Starts a run and returns the number of edges from acceptance to done.
  // At edge inj_at a start/cfg_we/init burst is driven while the run is active.
  task automatic do_run(input int steps, input int inj_at, output int lat);
    int budget;
    budget = steps * PER_STEP + 40;
    obs_q.delete();
    busy_drop = 0;
    num_steps = 16'(steps);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < budget) begin
      if (lat == inj_at) begin
        start = 1'b1; num_steps = 16'd5;
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 32'h00010000;
        init = 1'b1;
      end
      tick();
      lat++;
      start = 1'b0; cfg_we = 1'b0; init = 1'b0;
      if (dbg_state == 3'd3) obs_q.push_back(dp_current);
      if (done !== 1'b1 && busy !== 1'b1) busy_drop++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; rd_addr = 3'd3;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    n_cmp++; if (dp_current !== 32'h0) begin n_err++; $display("FAIL reset_dp_current: got %h want 0", dp_current); end
    n_cmp++; if (rd_v !== 32'h0) begin n_err++; $display("FAIL reset_rd_v_during: got %h want 0", rd_v); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    tick();
    n_cmp++; if (rd_v !== INIT_V) begin n_err++; $display("FAIL reset_rd_v: got %h want %h", rd_v, INIT_V); end
    n_cmp++; if (rd_r !== INIT_R) begin n_err++; $display("FAIL reset_rd_r: got %h want %h", rd_r, INIT_R); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_single_step();
    int lat;
    logic [W-1:0] v, r, e, o;
    logic [15:0] s;
    load_random_currents();
    exp_q.delete();
    model_run(1);
    do_run(1, -1, lat);
    n_cmp++; if (lat != PER_STEP) begin n_err++; $display("FAIL single_latency: got %0d want %0d", lat, PER_STEP); end
    n_cmp++; if (busy_drop != 0) begin n_err++; $display("FAIL single_busy: got %0d drops want 0", busy_drop); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_at_done: got %b want 0", busy); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_issue_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL single_dp_current: got %h want %h", o, e); end
    end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse: got %b want 0", done); end
    n_cmp++; if (dp_current !== m_cur[N-1]) begin n_err++; $display("FAIL single_dp_hold: got %h want %h", dp_current, m_cur[N-1]); end
    for (int i = 0; i < N; i++) begin
      read_neuron(i, v, r, s);
      n_cmp++; if (v !== 32'h8000CCCE) begin n_err++; $display("FAIL single_v[%0d]: got %h want 8000ccce", i, v); end
      n_cmp++; if (r !== m_r[i]) begin n_err++; $display("FAIL single_r[%0d]: got %h want %h", i, r, m_r[i]); end
    end
  endtask

  task automatic test_zero_steps();
    int lat;
    logic [W-1:0] v, r;
    logic [15:0] s;
    do_run(0, -1, lat);
    n_cmp++; if (lat != 0 || done !== 1'b1) begin n_err++; $display("FAIL zero_done: got lat=%0d done=%b want 0 1", lat, done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy); end
    for (int i = 0; i < N; i++) begin
      read_neuron(i, v, r, s);
      n_cmp++; if (v !== m_v[i] || r !== m_r[i]) begin n_err++; $display("FAIL zero_state[%0d]: got %h/%h want %h/%h", i, v, r, m_v[i], m_r[i]); end
    end
  endtask

  task automatic test_ignored_while_busy();
    int lat;
    logic [W-1:0] v, r, e, o;
    logic [15:0] s;
    exp_q.delete();
    model_run(2);
    do_run(2, 30, lat);
    n_cmp++; if (lat != 2 * PER_STEP) begin n_err++; $display("FAIL ignored_latency: got %0d want %0d", lat, 2 * PER_STEP); end
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_no_requeue: got busy=%b want 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL ignored_dp_current: got %h want %h", o, e); end
    end
    for (int i = 0; i < N; i++) begin
      read_neuron(i, v, r, s);
      n_cmp++; if (v !== m_v[i] || r !== m_r[i]) begin n_err++; $display("FAIL ignored_state[%0d]: got %h/%h want %h/%h", i, v, r, m_v[i], m_r[i]); end
    end
  endtask

  task automatic test_cfg_and_init_same_cycle();
    int lat;
    logic [W-1:0] v, r, e, o, d;
    logic [15:0] s;
    d = $urandom;
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = d; init = 1'b1;
    tick();
    cfg_we = 1'b0; init = 1'b0;
    m_cur[5] = d;
    model_init();
    read_neuron(5, v, r, s);
    n_cmp++; if (v !== INIT_V || r !== INIT_R) begin n_err++; $display("FAIL both_init: got %h/%h want %h/%h", v, r, INIT_V, INIT_R); end
    exp_q.delete();
    model_run(1);
    do_run(1, -1, lat);
    n_cmp++; if (lat != PER_STEP) begin n_err++; $display("FAIL both_latency: got %0d want %0d", lat, PER_STEP); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL both_dp_current: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int done_seen;
    logic [W-1:0] v, r;
    logic [15:0] s;
    load_random_currents();
    done_seen = 0;
    num_steps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || dbg_state !== 3'd0) begin n_err++; $display("FAIL midrst_abort: got busy=%b state=%0d want 0 0", busy, dbg_state); end
    n_cmp++; if (dp_current !== 32'h0) begin n_err++; $display("FAIL midrst_dp: got %h want 0", dp_current); end
    tick();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
    for (int i = 0; i < N; i++) begin
      read_neuron(i, v, r, s);
      n_cmp++; if (v !== INIT_V || r !== INIT_R) begin n_err++; $display("FAIL midrst_state[%0d]: got %h/%h want %h/%h", i, v, r, INIT_V, INIT_R); end
    end
    load_random_currents();
    exp_q.delete();
    model_run(1);
    do_run(1, -1, lat);
    n_cmp++; if (lat != PER_STEP) begin n_err++; $display("FAIL midrst_fresh_latency: got %0d want %0d", lat, PER_STEP); end
    for (int i = 0; i < N; i++) begin
      read_neuron(i, v, r, s);
      n_cmp++; if (v !== m_v[i] || r !== m_r[i]) begin n_err++; $display("FAIL midrst_fresh[%0d]: got %h/%h want %h/%h", i, v, r, m_v[i], m_r[i]); end
    end
  endtask

  task automatic test_random_runs();
    int lat, steps;
    logic [W-1:0] v, r, e, o;
    logic [15:0] s;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 3; k++) cfg_write($urandom_range(0, N - 1), $urandom);
      steps = $urandom_range(1, 3);
      exp_q.delete();
      model_run(steps);
      do_run(steps, -1, lat);
      n_cmp++; if (lat != steps * PER_STEP) begin n_err++; $display("FAIL rand_latency: got %0d want %0d", lat, steps * PER_STEP); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        n_cmp++; if (o !== e) begin n_err++; $display("FAIL rand_dp_current: got %h want %h", o, e); end
      end
      for (int i = 0; i < N; i++) begin
        read_neuron(i, v, r, s);
        n_cmp++; if (v !== m_v[i] || r !== m_r[i]) begin n_err++; $display("FAIL rand_state[%0d]: got %h/%h want %h/%h", i, v, r, m_v[i], m_r[i]); end
      end
    end
  endtask

`ifdef SPIKE_COUNT_EN
  task automatic test_spike_count();
    int lat;
    logic [W-1:0] v, r;
    logic [15:0] s;
    pulse_init();
    spike_mode = 1'b1;
    exp_q.delete();
    model_run(4);
    do_run(4, -1, lat);
    n_cmp++; if (lat != 4 * PER_STEP) begin n_err++; $display("FAIL spike_latency: got %0d want %0d", lat, 4 * PER_STEP); end
    for (int i = 0; i < N; i++) begin
      read_neuron(i, v, r, s);
      n_cmp++; if (s !== 16'(m_spk[i]) || s !== 16'd2) begin n_err++; $display("FAIL spike_count[%0d]: got %0d want %0d", i, s, m_spk[i]); end
    end
    spike_mode = 1'b0;
    pulse_init();
    for (int i = 0; i < N; i++) begin
      read_neuron(i, v, r, s);
      n_cmp++; if (s !== 16'd0) begin n_err++; $display("FAIL spike_clear[%0d]: got %0d want 0", i, s); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_step();
    test_zero_steps();
    test_ignored_while_busy();
    test_cfg_and_init_same_cycle();
    test_reset_mid_run();
    test_random_runs();
`ifdef SPIKE_COUNT_EN
    test_spike_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
